// File: rtl/axi_sram_arbiter_if.sv
// Single-beat AXI3 master bus driven by axi_sram_arbiter.
// The master modport is the arbiter side; the slave modport is the memory side.
interface axi_sram_arbiter_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_arbiter.sv
// Arbitrates NUM_CH SRAM-like requesters onto one single-beat AXI3 master with one
// transaction in flight, kseg address translation and per-channel response flush.
module axi_sram_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ARB_RR   = 0,
  parameter int KSEG_MAP = 1,
  parameter int ID_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_wr,
  input  logic [2*NUM_CH-1:0]   ch_size,
  input  logic [4*NUM_CH-1:0]   ch_wstrb,
  input  logic [32*NUM_CH-1:0]  ch_addr,
  input  logic [32*NUM_CH-1:0]  ch_wdata,
  input  logic [NUM_CH-1:0]     ch_flush,
  output logic [NUM_CH-1:0]     ch_ready,
  output logic [31:0]           ch_rdata,
  axi_sram_arbiter_if.master    axi
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] grant, rr_ptr, sel, idx;
  logic             sel_valid;
  logic             flush_q, flush_hit;
  logic             aw_done, w_done;
  logic [1:0]       size_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      addr_q, wdata_q, rdata_q, bus_addr;
  logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic             unused_ok;

  logic [31:0] addr_arr  [NUM_CH];
  logic [31:0] wdata_arr [NUM_CH];
  logic [3:0]  wstrb_arr [NUM_CH];
  logic [1:0]  size_arr  [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign addr_arr[k]  = ch_addr[32*k +: 32];
    assign wdata_arr[k] = ch_wdata[32*k +: 32];
    assign wstrb_arr[k] = ch_wstrb[4*k +: 4];
    assign size_arr[k]  = ch_size[2*k +: 2];
  end

  // Candidate grant: scan from the RR pointer (or from 0 for fixed priority)
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_RR != 0) idx = IDX_W'((int'(rr_ptr) + k) % NUM_CH);
      else             idx = IDX_W'(k);
      if (!sel_valid && ch_req[idx]) begin
        sel       = idx;
        sel_valid = 1'b1;
      end
    end
  end

  assign ar_hs     = axi.arvalid && axi.arready;
  assign r_hs      = axi.rvalid  && axi.rready;
  assign aw_hs     = axi.awvalid && axi.awready;
  assign w_hs      = axi.wvalid  && axi.wready;
  assign b_hs      = axi.bvalid  && axi.bready;
  assign flush_hit = flush_q || ch_flush[grant];
  assign bus_addr  = (KSEG_MAP != 0 && addr_q[31]) ? {3'b000, addr_q[28:0]} : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      flush_q <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      size_q  <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_valid) begin
        grant   <= sel;
        addr_q  <= addr_arr[sel];
        size_q  <= size_arr[sel];
        wstrb_q <= wstrb_arr[sel];
        wdata_q <= wdata_arr[sel];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (int'(sel) == NUM_CH - 1) rr_ptr <= '0;
        else                         rr_ptr <= sel + 1'b1;
      end
      if (state == AW_W && aw_hs) aw_done <= 1'b1;
      if (state == AW_W && w_hs)  w_done  <= 1'b1;
      // A flushed response still completes on the bus but never reaches the requester
      if (state == DONE)                        flush_q <= 1'b0;
      else if (state != IDLE && ch_flush[grant]) flush_q <= 1'b1;
      if (state == R && r_hs && !flush_hit) rdata_q <= axi.rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    ch_ready    = '0;
    case (state)
      IDLE: if (sel_valid) state_nxt = ch_wr[sel] ? AW_W : AR;
      AR: begin
        axi.arvalid = 1'b1;
        if (ar_hs) state_nxt = R;
      end
      R: begin
        axi.rready = 1'b1;
        if (r_hs) state_nxt = DONE;
      end
      AW_W: begin
        axi.awvalid = !aw_done;
        axi.wvalid  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = B;
      end
      B: begin
        axi.bready = 1'b1;
        if (b_hs) state_nxt = DONE;
      end
      DONE: begin
        if (!flush_q) ch_ready[grant] = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ch_rdata    = rdata_q;

  assign axi.arid    = ID_W'(grant);
  assign axi.araddr  = bus_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  assign axi.awid    = ID_W'(grant);
  assign axi.awaddr  = bus_addr;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;

  assign axi.wid     = ID_W'(grant);
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;

  assign unused_ok = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Self-checking bench: a 2-channel fixed-priority kseg instance with a latency-programmable
// slave, and a 4-channel round-robin pass-through instance with a zero-wait slave.
module tb_axi_sram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Instance A: 2 channels, fixed priority, kseg translation
  axi_sram_arbiter_if #(.ID_W(4)) ifa ();
  logic [1:0]  a_req = '0, a_wr = '0, a_flush = '0, a_ready;
  logic [3:0]  a_size = '0;
  logic [7:0]  a_wstrb = '0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata;

  axi_sram_arbiter #(.NUM_CH(2), .ARB_RR(0), .KSEG_MAP(1), .ID_W(4)) dut_a (
    .clk(clk), .rst(rst), .ch_req(a_req), .ch_wr(a_wr), .ch_size(a_size),
    .ch_wstrb(a_wstrb), .ch_addr(a_addr), .ch_wdata(a_wdata), .ch_flush(a_flush),
    .ch_ready(a_ready), .ch_rdata(a_rdata), .axi(ifa)
  );

  // Instance B: 4 channels, round-robin, no translation, reads only
  axi_sram_arbiter_if #(.ID_W(4)) ifb ();
  logic [3:0]   b_req = '0, b_ready;
  logic [31:0]  b_rdata;
  logic [31:0]  b_addr_arr [4];
  logic [127:0] b_addr;

  always_comb begin
    b_addr = '0;
    for (int k = 0; k < 4; k++) b_addr[32*k +: 32] = b_addr_arr[k];
  end

  axi_sram_arbiter #(.NUM_CH(4), .ARB_RR(1), .KSEG_MAP(0), .ID_W(4)) dut_b (
    .clk(clk), .rst(rst), .ch_req(b_req), .ch_wr(4'b0000), .ch_size(8'hAA),
    .ch_wstrb(16'h0000), .ch_addr(b_addr), .ch_wdata(128'h0), .ch_flush(4'b0000),
    .ch_ready(b_ready), .ch_rdata(b_rdata), .axi(ifb)
  );

  assign ifb.arready = 1'b1;
  assign ifb.rvalid  = ifb.rready;
  assign ifb.rdata   = ifb.araddr ^ 32'hFFFF_0000;
  assign ifb.rid     = '0;
  assign ifb.rresp   = '0;
  assign ifb.rlast   = 1'b1;
  assign ifb.awready = 1'b1;
  assign ifb.wready  = 1'b1;
  assign ifb.bvalid  = ifb.bready;
  assign ifb.bid     = '0;
  assign ifb.bresp   = '0;

  // Slave A: each ready/valid rises once its partner has waited more than the programmed latency
  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] slv_data = '0;

  initial begin
    ifa.arready = 1'b0; ifa.rvalid = 1'b0; ifa.rdata = '0; ifa.rid = '0;
    ifa.rresp = '0; ifa.rlast = 1'b1; ifa.awready = 1'b0; ifa.wready = 1'b0;
    ifa.bvalid = 1'b0; ifa.bid = '0; ifa.bresp = '0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ifa.arready = 1'b0; ifa.rvalid = 1'b0; ifa.awready = 1'b0;
      ifa.wready = 1'b0; ifa.bvalid = 1'b0;
    end else begin
      #1;
      ar_cnt = ifa.arvalid ? ar_cnt + 1 : 0;
      r_cnt  = ifa.rready  ? r_cnt + 1  : 0;
      aw_cnt = ifa.awvalid ? aw_cnt + 1 : 0;
      w_cnt  = ifa.wvalid  ? w_cnt + 1  : 0;
      b_cnt  = ifa.bready  ? b_cnt + 1  : 0;
      ifa.arready = ifa.arvalid && (ar_cnt > ar_lat);
      ifa.rvalid  = ifa.rready  && (r_cnt > r_lat);
      ifa.rdata   = ifa.rvalid ? slv_data : 32'hDEAD_BEEF;
      ifa.awready = ifa.awvalid && (aw_cnt > aw_lat);
      ifa.wready  = ifa.wvalid  && (w_cnt > w_lat);
      ifa.bvalid  = ifa.bready  && (b_cnt > b_lat);
    end
  end

  logic [31:0] model_rdata = '0;
  int          b_ptr_model = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rrPick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // One transaction on instance A from a single channel, checked cycle by cycle
  task automatic applyStimulus(input int ch, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int lar, input int lr,
                               input int law, input int lw, input int lb,
                               input bit do_flush, input logic [31:0] data);
    logic [31:0] exp_addr;
    bit aw_seen, w_seen, flushed, done, zero_wait;
    int resp_cyc;
    exp_addr  = addr[31] ? (addr & 32'h1FFF_FFFF) : addr;
    aw_seen   = 0; w_seen = 0; flushed = 0; done = 0; resp_cyc = -1;
    zero_wait = (lar + lr + law + lw + lb == 0) && !do_flush;
    ar_lat = lar; r_lat = lr; aw_lat = law; w_lat = lw; b_lat = lb; slv_data = data;
    @(posedge clk); #1;
    a_wr[ch] = wr; a_size[2*ch +: 2] = size; a_addr[32*ch +: 32] = addr;
    a_wdata[32*ch +: 32] = wdata; a_wstrb[4*ch +: 4] = wstrb; a_req[ch] = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (a_flush != 0) a_flush = '0;
      if (resp_cyc >= 0 && cyc == resp_cyc + 1) begin
        checkOutput("ch_ready", a_ready, flushed ? 0 : (1 << ch));
        checkOutput("ch_rdata", a_rdata, model_rdata);
        if (zero_wait) checkOutput("latency", cyc, 3);
        a_req[ch] = 1'b0;
        done = 1;
      end else if (a_ready != 0) begin
        checkOutput("spurious_ready", a_ready, 0);
      end
      if (ifa.arvalid && ifa.arready) begin
        checkOutput("araddr", ifa.araddr, exp_addr);
        checkOutput("arsize", ifa.arsize, {1'b0, size});
        checkOutput("arid", ifa.arid, ch);
      end
      if (ifa.awvalid && ifa.awready) begin
        checkOutput("awaddr", ifa.awaddr, exp_addr);
        checkOutput("awid", ifa.awid, ch);
      end
      if (ifa.wvalid && ifa.wready) begin
        checkOutput("wdata", ifa.wdata, wdata);
        checkOutput("wstrb", ifa.wstrb, wstrb);
      end
      if (aw_seen && !w_seen) checkOutput("aw_dropped", {ifa.awvalid, ifa.wvalid}, 2'b01);
      if (w_seen && !aw_seen) checkOutput("w_dropped", {ifa.awvalid, ifa.wvalid}, 2'b10);
      if (ifa.bready) checkOutput("bready_order", aw_seen && w_seen, 1);
      if (ifa.awvalid && ifa.awready) aw_seen = 1;
      if (ifa.wvalid && ifa.wready) w_seen = 1;
      if (do_flush && !flushed && (ifa.rready || ifa.bready)) begin
        a_flush[ch] = 1'b1;
        flushed = 1;
        a_req[ch] = 1'b0;
      end
      if ((ifa.rvalid && ifa.rready) || (ifa.bvalid && ifa.bready)) begin
        resp_cyc = cyc;
        if (!wr && !flushed) model_rdata = data;
      end
    end
    checkOutput("completed", done, 1);
  endtask

  // Round-robin traffic on instance B; pending requests are held until served
  task automatic applyRoundRobin(input logic [3:0] mask0, input int grants, input bit rand_new,
                                 input logic [31:0] addr_or);
    logic [3:0] pend, newm;
    int exp_g, served;
    pend = mask0; served = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) if (pend[k]) b_addr_arr[k] = (addr_or != 0) ? addr_or : $urandom;
    b_req = pend;
    exp_g = rrPick(pend, b_ptr_model);
    for (int cyc = 0; cyc < 400 && served < grants; cyc++) begin
      @(negedge clk);
      if (ifb.arvalid) begin
        checkOutput("rr_arid", ifb.arid, exp_g);
        checkOutput("rr_araddr", ifb.araddr, b_addr_arr[exp_g]);
      end
      if (b_ready != 0) begin
        checkOutput("rr_ready", b_ready, 1 << exp_g);
        checkOutput("rr_rdata", b_rdata, b_addr_arr[exp_g] ^ 32'hFFFF_0000);
        served++;
        b_ptr_model = (exp_g + 1) % 4;
        pend[exp_g] = 1'b0;
        if (served >= grants) begin
          pend = '0;
        end else if (rand_new) begin
          newm = 4'($urandom_range(0, 15)) & ~pend;
          if (pend == 0 && newm == 0) newm = 4'(1 << $urandom_range(0, 3));
          for (int k = 0; k < 4; k++) if (newm[k]) b_addr_arr[k] = $urandom;
          pend = pend | newm;
        end
        b_req = pend;
        exp_g = rrPick(pend, b_ptr_model);
      end
    end
    checkOutput("rr_served", served, grants);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants;
    for (int k = 0; k < 4; k++) b_addr_arr[k] = '0;
    #2;
    checkOutput("rst_arvalid", ifa.arvalid, 0);
    checkOutput("rst_awwvalid", {ifa.awvalid, ifa.wvalid}, 0);
    checkOutput("rst_rbready", {ifa.rready, ifa.bready}, 0);
    checkOutput("rst_ch_ready", a_ready, 0);
    checkOutput("rst_ch_rdata", a_rdata, 0);
    checkOutput("rst_b_ready", b_ready, 0);
    #10 rst = 1'b0;

    $display("[TB] directed read, write, flush");
    applyStimulus(1, 0, 2, 32'hBFAF_0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
    applyStimulus(0, 1, 2, 32'h0000_1004, 32'hAABB_CCDD, 4'b0011, 0, 0, 0, 2, 0, 0, 32'h0);
    applyStimulus(1, 0, 2, 32'h0000_2000, 0, 0, 0, 4, 0, 0, 0, 1, 32'hFEED_0001);
    applyStimulus(1, 0, 1, 32'h8000_0040, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555_AAAA);

    $display("[TB] fixed priority with both channels requesting");
    ar_lat = 0; r_lat = 0; slv_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    a_wr = '0; a_size = 4'b1010; a_addr = {32'h0000_2000, 32'h0000_1000}; a_req = 2'b11;
    grants = 0;
    for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
      @(negedge clk);
      if (ifa.arvalid && ifa.arready) checkOutput("fp_arid", ifa.arid, 0);
      if (a_ready != 0) begin
        checkOutput("fp_ready", a_ready, 2'b01);
        checkOutput("fp_rdata", a_rdata, 32'h0BAD_F00D);
        grants++;
        if (grants == 4) a_req = '0;
      end
    end
    checkOutput("fp_grants", grants, 4);
    model_rdata = 32'h0BAD_F00D;

    $display("[TB] randomized transactions");
    for (int n = 0; n < 24; n++) begin
      applyStimulus($urandom_range(0, 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    $urandom, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("[TB] asynchronous reset during write");
    aw_lat = 6; w_lat = 6;
    @(posedge clk); #1;
    a_wr[1] = 1'b1; a_addr[63:32] = 32'h0000_3000; a_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_valids", {ifa.awvalid, ifa.wvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valids", {ifa.awvalid, ifa.wvalid}, 2'b00);
    checkOutput("mid_rst_ready", a_ready, 0);
    checkOutput("mid_rst_rdata", a_rdata, 0);
    a_req = '0; a_wr = '0; model_rdata = '0; b_ptr_model = 0;
    #1 rst = 1'b0;
    applyStimulus(1, 0, 2, 32'hA000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_0042);

    $display("[TB] round-robin on four channels");
    applyRoundRobin(4'b0100, 1, 0, 32'h8000_0000);
    applyRoundRobin(4'b1100, 2, 0, 32'h8000_0000);
    applyRoundRobin(4'($urandom_range(1, 15)), 16, 1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/axi_sram_arbiter.md
Name: axi_sram_arbiter

Overview:
- Parametrised successor to the two-port inst/data memory mux that currently feeds axi_interface.
- Accepts NUM_CH SRAM-like requesters (channel 0 = inst fetch, 1 = data, further channels for future caches/DMA).
- Arbitrates among them with a fixed-priority or round-robin policy, applies kseg address translation, and drives one single-beat AXI3 master with one outstanding transaction.
- Supports per-channel flush, which silently discards the response of a granted transaction.

Parameters:
NUM_CH, 2, number of requester channels (1..8)
ARB_RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
KSEG_MAP, 1, 1 = translate addresses with addr[31]=1 to {3'b000, addr[28:0]}
ID_W, 4, AXI id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ch_req  in  NUM_CH  request; held with fields stable until ch_ready or ch_flush
ch_wr  in  NUM_CH  1 = write, 0 = read
ch_size  in  2*NUM_CH  0 = byte, 1 = half, 2 = word
ch_wstrb  in  4*NUM_CH  write byte strobes
ch_addr  in  32*NUM_CH  virtual address
ch_wdata  in  32*NUM_CH  write data
ch_flush  in  NUM_CH  cancel own transaction's response
ch_ready  out  NUM_CH  one-cycle completion pulse
ch_rdata  out  32  read data, valid with ch_ready
arid/araddr/arlen(8)/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI AR channel
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  AXI R channel (rid, rresp, rlast ignored)
rready  out  1
awid/awaddr/awlen(4)/awsize/awburst/awlock/awcache/awprot/awvalid  out  AXI AW channel
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  AXI W channel
wready  in  1
bid/bresp/bvalid  in  AXI B channel (bid, bresp ignored)
bready  out  1

Behaviour:
- Reset: asynchronous; forces IDLE immediately, including mid-transaction.
  - All valid/ready outputs 0, ch_ready 0, ch_rdata 0.
  - RR pointer 0, grant index 0, flush latch 0.
- Constant outputs:
  - arlen = 0, awlen = 0, arburst = awburst = 2'b01, wlast = 1.
  - lock/cache/prot = 0.
  - arid = awid = wid = grant index, zero-extended to ID_W.
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE: when any ch_req is high, select grant g.
  - Fixed priority: lowest set index.
  - RR: first set index at or after the pointer, wrapping modulo NUM_CH.
  - Register g and latch addr, size, wstrb, wdata and wr from channel g.
  - Next state: AR if read, AW_W if write.
  - RR pointer becomes (g+1) mod NUM_CH on every grant.
- Address output = (KSEG_MAP && addr[31]) ? {3'b000, addr[28:0]} : addr.
- Size output = {1'b0, size}.
- AR: arvalid = 1 until the arready handshake, then go to R.
- R: rready = 1; on rvalid, capture rdata into the holding register and go to DONE.
- AW_W: awvalid and wvalid both asserted on entry.
  - Each deasserts after its own handshake; separate aw_done/w_done flags are required.
  - When both handshakes are done (same or different cycles), go to B.
  - wdata/wstrb come from the latched fields.
- B: bready = 1; on bvalid go to DONE.
- DONE: ch_ready[g] = 1 for exactly this cycle (suppressed if the flush latch is set); next state IDLE.
  - The requester deasserts or renews ch_req at this edge.
  - IDLE never grants in the same cycle a ch_ready pulses.
- ch_rdata holds the last captured read data until the next read completes (writes leave it unchanged).
- Flush:
  - ch_flush[g] high in any non-IDLE cycle sets the flush latch.
  - The AXI transaction still runs to its response (no abort on the bus).
  - DONE then pulses no ch_ready; the latch clears on leaving DONE.
  - ch_flush on a non-granted channel has no effect.
- Minimum latency, zero-wait slave: req seen in IDLE at cycle 0 → handshake cycle 1 → response cycle 2 → ch_ready in cycle 3. Writes take the same cycles.
- Only one transaction is outstanding; other channels wait with req held.

Test Plan:
- Single read, ch1 addr 0xBFAF_0010, size 2, zero-wait slave → araddr 0x1FAF_0010, arsize 2, arid 1; ch_ready = 2'b10 exactly at cycle 3; ch_rdata = slave data 0x1234_5678.
- Write with awready 2 cycles before wready, wstrb 4'b0011, wdata 0xAABB_CCDD → awvalid drops after its handshake while wvalid is held; bready only after both handshakes; one ch_ready pulse on that channel.
- Both channels requesting continuously:
  - ARB_RR = 0 → ch0 granted every time and ch1 starves.
  - ARB_RR = 1 → grants alternate 0,1,0,1 with arid matching.
- Flush ch1 during R state, rvalid 4 cycles later → rready handshake completes; no ch_ready pulse; ch_rdata unchanged; next request is served normally.
- Reset asserted during AW_W (async, mid-cycle) → awvalid/wvalid drop before the next edge; after release the FSM is in IDLE and a new request is granted.
- NUM_CH = 4, KSEG_MAP = 0, requests on ch2 and ch3 with RR pointer at 3 → ch3 granted first, then ch2; addr 0x8000_0000 passes through untranslated.
